// File: rtl/cv32e40p_reg_bank_par.sv
// Register bank with even parity per GROUP_WIDTH-bit slice, a registered read port,
// a background scrubber and first-error capture for the safety logic.
module cv32e40p_reg_bank_par #(
    parameter int DATA_WIDTH  = 32,
    parameter int GROUP_WIDTH = 8,
    parameter int DEPTH       = 4,
    parameter int CNT_WIDTH   = 4,
    localparam int NGROUPS    = DATA_WIDTH / GROUP_WIDTH,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  inj_err_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    output logic                  rerr_o,
    input  logic                  scrub_en_i,
    output logic                  scrub_pass_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o,
    output logic                  err_sticky_o,
    output logic [AW-1:0]         err_addr_o,
    input  logic                  clr_i
);

    typedef enum logic {SCRUB_IDLE, SCRUB_SCAN} scrub_state_t;

    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [NGROUPS-1:0]    mem_par  [DEPTH];
    logic [AW-1:0]         scrub_ptr;

    scrub_state_t          scrub_state;
    logic [NGROUPS-1:0]    wpar;
    logic                  rd_err;
    logic                  sc_err;
    logic                  scrub_chk;
    logic                  err_ev;
    logic [AW-1:0]         err_ev_addr;

    function automatic logic [NGROUPS-1:0] calc_par(input logic [DATA_WIDTH-1:0] d);
        logic [NGROUPS-1:0] p;
        p = '0;
        for (int g = 0; g < NGROUPS; g++) begin
            p[g] = ^d[g*GROUP_WIDTH +: GROUP_WIDTH];
        end
        return p;
    endfunction

    // Injection flips only the group-0 parity bit, so the data itself stays intact.
    assign wpar   = calc_par(wdata_i) ^ NGROUPS'(inj_err_i);
    assign rd_err = |(calc_par(mem_data[raddr_i]) ^ mem_par[raddr_i]);
    assign sc_err = |(calc_par(mem_data[scrub_ptr]) ^ mem_par[scrub_ptr]);

    // The scrubber only gets the bank in cycles without core traffic.
    always_comb begin
        scrub_state = scrub_en_i ? SCRUB_SCAN : SCRUB_IDLE;
        scrub_chk   = (scrub_state == SCRUB_SCAN) && !we_i && !re_i;
        err_ev      = (re_i && rd_err) || (scrub_chk && sc_err);
        err_ev_addr = re_i ? raddr_i : scrub_ptr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_par[i]  <= '0;
            end
        end else if (we_i) begin
            mem_data[waddr_i] <= wdata_i;
            mem_par[waddr_i]  <= wpar;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
            rerr_o   <= 1'b0;
        end else begin
            rvalid_o <= re_i;
            rerr_o   <= re_i && rd_err;
            if (re_i) begin
                rdata_o <= mem_data[raddr_i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scrub_ptr    <= '0;
            scrub_pass_o <= 1'b0;
        end else begin
            scrub_pass_o <= scrub_chk && (scrub_ptr == AW'(DEPTH - 1));
            if (scrub_chk) begin
                if (scrub_ptr == AW'(DEPTH - 1)) begin
                    scrub_ptr <= '0;
                end else begin
                    scrub_ptr <= scrub_ptr + 1'b1;
                end
            end
        end
    end

    // A clear in the same cycle as an event leaves exactly that event recorded.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_o    <= '0;
            err_sticky_o <= 1'b0;
            err_addr_o   <= '0;
        end else if (clr_i) begin
            err_cnt_o    <= err_ev ? CNT_WIDTH'(1) : '0;
            err_sticky_o <= err_ev;
            err_addr_o   <= err_ev ? err_ev_addr : '0;
        end else if (err_ev) begin
            if (err_cnt_o != '1) begin
                err_cnt_o <= err_cnt_o + 1'b1;
            end
            if (!err_sticky_o) begin
                err_sticky_o <= 1'b1;
                err_addr_o   <= err_ev_addr;
            end
        end
    end

endmodule
